// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter controller for the decoder core. Sequences instruction
//   fetch from start until a halt instruction. Taken branches are mapped to
//   fetch addresses through a writable branch-target table indexed by the
//   branch immediate. Run status and saturating performance counters are
//   exposed to the host.
//
// Parameters
//   PC_W      width of program counter / instruction address
//   IMM_W     width of branch immediate (table has 2**IMM_W entries)
//   CNT_W     width of cycle and taken-branch counters
//   START_PC  PC loaded on start
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          begin execution (honoured in IDLE or HALTED)
//   cfg_we/idx/addr  branch-table write port (ignored while running)
//   stall          hold PC this cycle
//   branch_taken   branch decision for the current instruction
//   branch_imm     branch immediate, selects the table entry
//   halt           current instruction is the halt instruction
//   pc             current fetch address
//   fetch_en       instruction at pc is valid for execution
//   busy           high while running
//   done           high after halt until next start or reset
//   cycle_cnt      running cycles since last start, saturating
//   taken_cnt      taken branches since last start, saturating
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int          PC_W     = 10,
    parameter int          IMM_W    = 5,
    parameter int          CNT_W    = 16,
    parameter int unsigned START_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [IMM_W-1:0] cfg_idx,
    input  logic [PC_W-1:0]  cfg_addr,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [IMM_W-1:0] branch_imm,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int DEPTH = 2 ** IMM_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t          state;
    logic [PC_W-1:0] branch_table [DEPTH];
    logic [PC_W-1:0] branch_target;

    // Combinational lookup of the registered table contents.
    assign branch_target = branch_table[branch_imm];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            fetch_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            taken_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                branch_table[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, HALTED: begin
                    // Table is only writable while not running; a write and
                    // a start in the same cycle both take effect.
                    if (cfg_we) begin
                        branch_table[cfg_idx] <= cfg_addr;
                    end
                    if (start) begin
                        state     <= RUN;
                        pc        <= PC_W'(START_PC);
                        fetch_en  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cycle_cnt <= '0;
                        taken_cnt <= '0;
                    end
                end
                RUN: begin
                    // Every running cycle counts, including stalls and the
                    // halt cycle itself.
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                    // Stall freezes the PC and masks halt and branch.
                    if (!stall) begin
                        if (halt) begin
                            state    <= HALTED;
                            fetch_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (branch_taken) begin
                            pc <= branch_target;
                            if (taken_cnt != '1) begin
                                taken_cnt <= taken_cnt + CNT_W'(1);
                            end
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. Two instances share the stimulus:
//   inst0 uses the default parameters, inst1 starts at PC 1020 with 4-bit
//   counters so wrap and saturation are reachable in a few cycles. A
//   behavioural model tracks both instances and is stepped once per clock.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cfg_we;
    logic [4:0] cfg_idx;
    logic [9:0] cfg_addr;
    logic       stall;
    logic       branch_taken;
    logic [4:0] branch_imm;
    logic       halt;

    logic [9:0]  pc0, pc1;
    logic        fetch_en0, fetch_en1, busy0, busy1, done0, done1;
    logic [15:0] cycle_cnt0, taken_cnt0;
    logic [3:0]  cycle_cnt1, taken_cnt1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one slot per instance.
    int m_pc    [2];
    int m_cyc   [2];
    int m_tk    [2];
    int m_max   [2];
    int m_start [2];
    int m_tbl   [2][32];
    bit m_run   [2];
    bit m_halted[2];

    always #5 clk = ~clk;

    pc_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm), .halt(halt),
        .pc(pc0), .fetch_en(fetch_en0), .busy(busy0), .done(done0),
        .cycle_cnt(cycle_cnt0), .taken_cnt(taken_cnt0)
    );

    pc_sequencer #(.START_PC(1020), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm), .halt(halt),
        .pc(pc1), .fetch_en(fetch_en1), .busy(busy1), .done(done1),
        .cycle_cnt(cycle_cnt1), .taken_cnt(taken_cnt1)
    );

    function automatic int get_pc(int i);
        return (i == 0) ? int'(pc0) : int'(pc1);
    endfunction
    function automatic int get_cyc(int i);
        return (i == 0) ? int'(cycle_cnt0) : int'(cycle_cnt1);
    endfunction
    function automatic int get_tk(int i);
        return (i == 0) ? int'(taken_cnt0) : int'(taken_cnt1);
    endfunction
    function automatic logic get_busy(int i);
        return (i == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_fetch(int i);
        return (i == 0) ? fetch_en0 : fetch_en1;
    endfunction
    function automatic logic get_done(int i);
        return (i == 0) ? done0 : done1;
    endfunction

    // Advance the model with the inputs presented for this edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_run[i]    = 1'b0;
                m_halted[i] = 1'b0;
                m_pc[i]     = 0;
                m_cyc[i]    = 0;
                m_tk[i]     = 0;
                for (int j = 0; j < 32; j++) m_tbl[i][j] = 0;
            end else if (m_run[i]) begin
                if (m_cyc[i] < m_max[i]) m_cyc[i]++;
                if (!stall) begin
                    if (halt) begin
                        m_run[i]    = 1'b0;
                        m_halted[i] = 1'b1;
                    end else if (branch_taken) begin
                        m_pc[i] = m_tbl[i][branch_imm];
                        if (m_tk[i] < m_max[i]) m_tk[i]++;
                    end else begin
                        m_pc[i] = (m_pc[i] + 1) % 1024;
                    end
                end
            end else begin
                if (cfg_we) m_tbl[i][cfg_idx] = int'(cfg_addr);
                if (start) begin
                    m_run[i]    = 1'b1;
                    m_halted[i] = 1'b0;
                    m_pc[i]     = m_start[i];
                    m_cyc[i]    = 0;
                    m_tk[i]     = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (pc0 !== 10'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || fetch_en0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: pc=%0d busy=%b done=%b fetch_en=%b, expected 0/0/0/0",
                     pc0, busy0, done0, fetch_en0);
        end
        checks++;
        if (cycle_cnt0 !== 16'd0 || taken_cnt0 !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: cycle=%0d taken=%0d, expected 0/0",
                     cycle_cnt0, taken_cnt0);
        end
    endtask

    task automatic test_sequential();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc0 !== 10'd0 || fetch_en0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_run_cycle: pc=%0d fetch_en=%b busy=%b, expected 0/1/1",
                     pc0, fetch_en0, busy0);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (pc0 !== 10'(k) || pc1 !== 10'((1020 + k) % 1024)) begin
                errors++;
                $display("[TB] FAIL seq_pc step%0d: pc0=%0d pc1=%0d, expected %0d/%0d",
                         k, pc0, pc1, k, (1020 + k) % 1024);
            end
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (done0 !== 1'b1 || pc0 !== 10'd5 || cycle_cnt0 !== 16'd6 ||
            fetch_en0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_state: done=%b pc=%0d cycle=%0d fetch_en=%b busy=%b, expected 1/5/6/0/0",
                     done0, pc0, cycle_cnt0, fetch_en0, busy0);
        end
    endtask

    task automatic test_branch();
        cfg_we = 1'b1; cfg_idx = 5'd1;  cfg_addr = 10'd9;
        tick();
        cfg_idx = 5'd17; cfg_addr = 10'd4;
        tick();
        cfg_we = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (pc0 !== 10'd2) begin
            errors++;
            $display("[TB] FAIL branch_pre_pc: got %0d expected 2", pc0);
        end
        branch_taken = 1'b1; branch_imm = 5'd1;
        tick();
        checks++;
        if (pc0 !== 10'd9 || taken_cnt0 !== 16'd1 || pc1 !== 10'd9) begin
            errors++;
            $display("[TB] FAIL branch_imm1: pc0=%0d pc1=%0d taken=%0d, expected 9/9/1",
                     pc0, pc1, taken_cnt0);
        end
        branch_imm = 5'd17;
        tick();
        checks++;
        if (pc0 !== 10'd4 || taken_cnt0 !== 16'd2) begin
            errors++;
            $display("[TB] FAIL branch_imm17: pc=%0d taken=%0d, expected 4/2", pc0, taken_cnt0);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_imm = 5'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pc0 !== 10'd4 || taken_cnt0 !== 16'd2) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle%0d: pc=%0d taken=%0d, expected 4/2",
                         k, pc0, taken_cnt0);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc0 !== 10'd9 || taken_cnt0 !== 16'd3) begin
            errors++;
            $display("[TB] FAIL stall_release: pc=%0d taken=%0d, expected 9/3", pc0, taken_cnt0);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_cfg_in_run();
        cfg_we = 1'b1; cfg_idx = 5'd1; cfg_addr = 10'd100;
        tick();
        cfg_we = 1'b0;
        branch_taken = 1'b1; branch_imm = 5'd1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc0 !== 10'd9) begin
            errors++;
            $display("[TB] FAIL cfg_ignored_in_run: pc=%0d expected 9", pc0);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || pc0 !== 10'd0) begin
            errors++;
            $display("[TB] FAIL restart: done=%b busy=%b pc=%0d, expected 0/1/0", done0, busy0, pc0);
        end
        branch_taken = 1'b1; branch_imm = 5'd1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc0 !== 10'd100) begin
            errors++;
            $display("[TB] FAIL cfg_in_halted: pc=%0d expected 100", pc0);
        end
    endtask

    task automatic test_saturation();
        branch_taken = 1'b1; branch_imm = 5'd1;
        repeat (20) tick();
        branch_taken = 1'b0;
        checks++;
        if (cycle_cnt1 !== 4'd15 || taken_cnt1 !== 4'd15) begin
            errors++;
            $display("[TB] FAIL saturate_small: cycle=%0d taken=%0d, expected 15/15",
                     cycle_cnt1, taken_cnt1);
        end
        checks++;
        if (cycle_cnt0 !== 16'd21 || taken_cnt0 !== 16'd21) begin
            errors++;
            $display("[TB] FAIL count_wide: cycle=%0d taken=%0d, expected 21/21",
                     cycle_cnt0, taken_cnt0);
        end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (pc0 !== 10'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || fetch_en0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: pc=%0d busy=%b done=%b fetch_en=%b, expected 0/0/0/0",
                     pc0, busy0, done0, fetch_en0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        branch_taken = 1'b1; branch_imm = 5'd1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc0 !== 10'd0 || pc1 !== 10'd0) begin
            errors++;
            $display("[TB] FAIL table_cleared: pc0=%0d pc1=%0d, expected 0/0", pc0, pc1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            start        = ($urandom_range(0, 99) < 15);
            cfg_we       = ($urandom_range(0, 99) < 30);
            cfg_idx      = 5'($urandom_range(0, 7));
            cfg_addr     = 10'($urandom);
            stall        = ($urandom_range(0, 99) < 25);
            branch_taken = ($urandom_range(0, 99) < 30);
            branch_imm   = 5'($urandom_range(0, 7));
            halt         = ($urandom_range(0, 99) < 8);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (get_pc(i) != m_pc[i] || get_busy(i) !== m_run[i] ||
                    get_fetch(i) !== m_run[i] || get_done(i) !== m_halted[i]) begin
                    errors++;
                    $display("[TB] FAIL rand_status inst%0d cyc%0d: pc=%0d busy=%b fetch=%b done=%b, expected %0d/%b/%b/%b",
                             i, n, get_pc(i), get_busy(i), get_fetch(i), get_done(i),
                             m_pc[i], m_run[i], m_run[i], m_halted[i]);
                end
                checks++;
                if (get_cyc(i) != m_cyc[i] || get_tk(i) != m_tk[i]) begin
                    errors++;
                    $display("[TB] FAIL rand_counters inst%0d cyc%0d: cycle=%0d taken=%0d, expected %0d/%0d",
                             i, n, get_cyc(i), get_tk(i), m_cyc[i], m_tk[i]);
                end
            end
        end
        reset = 1'b0; start = 1'b0; cfg_we = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    endtask

    initial begin
        m_start[0] = 0;     m_start[1] = 1020;
        m_max[0]   = 65535; m_max[1]   = 15;
        reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0;
        stall = 1'b0; branch_taken = 1'b0; branch_imm = '0; halt = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_cfg_in_run();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
